// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory target for the CPU's MR/MW strobes. Holds DEPTH x 16-bit words.
//   Inserts WAIT_STATES wait cycles, then answers with a four-phase REQ/ACK handshake.
//
// Ports
//   clk     : single clock, rising edge
//   nreset  : asynchronous active-low reset (memory contents are not touched)
//   MR, MW  : read / write request levels; exactly one high in IDLE starts a transaction
//   ADDR    : word address, sampled at accept
//   WDATA   : write data, sampled at accept
//   RDATA   : read data, valid while ACK=1 after a read
//   ACK     : transaction complete, held until MR and MW are both low
//   BUSY    : high in every state except IDLE
//   ERR     : illegal strobe combination or out-of-range address, valid while ACK=1
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | waiting for exactly one strobe (both high -> illegal request)
// ST_WAIT | counting down wait states; the edge leaving with cnt=0 does the access
// ST_RESP | ACK/ERR/RDATA held until both strobes are low

module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       WDATA,
  output logic [15:0]       RDATA,
  output logic              ACK,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ILLEGAL} op_t;

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [3:0]          cnt_q;

  logic [15:0]         mem [DEPTH];

  logic                in_range;
  logic                access;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign mem_idx  = addr_q[IDX_W-1:0];
  assign access   = (state == ST_WAIT) && (cnt_q == 4'd0);
  // Reset forces state to IDLE asynchronously, so an uncommitted write can never land.
  assign mem_we   = access && (op_q == OP_WRITE) && in_range;

  // Storage has no reset; contents survive nreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      RDATA   <= '0;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Even with zero wait states one cycle is spent in WAIT, which is the
          // access edge: ACK is high after edge k+1+WAIT_STATES.
          if (MR ^ MW) begin
            op_q    <= MW ? OP_WRITE : OP_READ;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
            cnt_q   <= WAIT_INIT;
            BUSY    <= 1'b1;
            state   <= ST_WAIT;
          end else if (MR && MW) begin
            // Illegal request skips the wait sequence: ACK+ERR after one more edge.
            op_q  <= OP_ILLEGAL;
            cnt_q <= 4'd0;
            BUSY  <= 1'b1;
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ACK   <= 1'b1;
            state <= ST_RESP;
            case (op_q)
              OP_READ: begin
                RDATA <= in_range ? mem[mem_idx] : 16'h0000;
                ERR   <= !in_range;
              end
              OP_WRITE: begin
                ERR <= !in_range;
              end
              default: begin
                ERR <= 1'b1;
              end
            endcase
          end
        end

        ST_RESP: begin
          if (!MR && !MW) begin
            ACK   <= 1'b0;
            ERR   <= 1'b0;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder.
//   Instance 0: DEPTH=200, WAIT_STATES=2. Instance 1: DEPTH=256, WAIT_STATES=0.
//   A directed vector table plus hand sequences cover the corner cases, then random
//   transactions are compared with a reference model built on a plain word array.

module tb_data_mem_responder;

  localparam int ADDR_W = 8;
  localparam int DEPTH0 = 200;
  localparam int WS0    = 2;
  localparam int DEPTH1 = 256;
  localparam int WS1    = 0;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mr    [2];
  logic        mw    [2];
  logic [7:0]  addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic        err   [2];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH0), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .nreset(nreset), .MR(mr[0]), .MW(mw[0]), .ADDR(addr[0]),
    .WDATA(wdata[0]), .RDATA(rdata[0]), .ACK(ack[0]), .BUSY(busy[0]), .ERR(err[0])
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH1), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .nreset(nreset), .MR(mr[1]), .MW(mw[1]), .ADDR(addr[1]),
    .WDATA(wdata[1]), .RDATA(rdata[1]), .ACK(ack[1]), .BUSY(busy[1]), .ERR(err[1])
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [2][256];
  bit          known   [2][256];
  logic [15:0] ref_rd  [2];

  typedef struct {
    bit          r;
    bit          w;
    logic [7:0]  a;
    logic [15:0] wd;
    int          hold;
    bit          e;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Reference: expected latency (edges after accept until ACK), ERR and RDATA.
  task automatic model(input int d, input bit r, input bit w, input int a,
                       input logic [15:0] wd, output int lat, output bit e,
                       output logic [15:0] rd);
    if (r && w) begin
      lat = 1;
      e   = 1'b1;
    end else begin
      lat = 1 + ws_of(d);
      e   = (a >= depth_of(d));
      if (r) begin
        ref_rd[d] = e ? 16'h0000 : ref_mem[d][a];
      end else if (!e) begin
        ref_mem[d][a] = wd;
        known[d][a]   = 1'b1;
      end
    end
    rd = ref_rd[d];
  endtask

  // Full handshake; returns observed latency, ERR and RDATA at ACK.
  task automatic run_txn(input int d, input bit r, input bit w, input logic [7:0] a,
                         input logic [15:0] wd, input int hold, output int lat,
                         output bit e, output logic [15:0] rd);
    mr[d] = r; mw[d] = w; addr[d] = a; wdata[d] = wd;
    step();
    chk("busy_after_accept", 32'(busy[d]), 32'd1);
    chk("ack_after_accept", 32'(ack[d]), 32'd0);
    addr[d]  = 8'($urandom);
    wdata[d] = 16'($urandom);
    lat = 0;
    while (!ack[d] && lat < 40) begin
      step();
      lat++;
    end
    e  = err[d];
    rd = rdata[d];
    for (int i = 0; i < hold; i++) begin
      step();
      chk("held_ack", 32'(ack[d]), 32'd1);
      chk("held_busy", 32'(busy[d]), 32'd1);
      chk("held_rdata", 32'(rdata[d]), 32'(rd));
      chk("held_err", 32'(err[d]), 32'(e));
    end
    mr[d] = 1'b0; mw[d] = 1'b0;
    step();
    chk("release_ack", 32'(ack[d]), 32'd0);
    chk("release_busy", 32'(busy[d]), 32'd0);
    chk("release_err", 32'(err[d]), 32'd0);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_rdata", 32'(rdata[d]), 32'd0);
    chk("rst_ack", 32'(ack[d]), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_err", 32'(err[d]), 32'd0);
  endtask

  initial begin
    int          lat, mlat;
    bit          e, me;
    logic [15:0] rd, mrd;
    logic [7:0]  pool [8];
    int          d;
    bit          r, w;
    int          a;

    pool = '{8'h00, 8'h10, 8'h20, 8'hC7, 8'hC8, 8'hFF, 8'h33, 8'h80};

    tbl[0] = '{r:1'b0, w:1'b1, a:8'h10, wd:16'hBEEF, hold:0,  e:1'b0, rd:16'h0000};
    tbl[1] = '{r:1'b1, w:1'b0, a:8'h10, wd:16'h0000, hold:10, e:1'b0, rd:16'hBEEF};
    tbl[2] = '{r:1'b1, w:1'b1, a:8'h10, wd:16'hDEAD, hold:2,  e:1'b1, rd:16'hBEEF};
    tbl[3] = '{r:1'b1, w:1'b0, a:8'h10, wd:16'h0000, hold:0,  e:1'b0, rd:16'hBEEF};
    tbl[4] = '{r:1'b0, w:1'b1, a:8'd250, wd:16'h1234, hold:1, e:1'b1, rd:16'hBEEF};
    tbl[5] = '{r:1'b1, w:1'b0, a:8'd250, wd:16'h0000, hold:0, e:1'b1, rd:16'h0000};
    tbl[6] = '{r:1'b0, w:1'b1, a:8'd199, wd:16'h5A5A, hold:0, e:1'b0, rd:16'h0000};
    tbl[7] = '{r:1'b1, w:1'b0, a:8'd199, wd:16'h0000, hold:0, e:1'b0, rd:16'h5A5A};
    tbl[8] = '{r:1'b0, w:1'b1, a:8'h20, wd:16'h1111, hold:0,  e:1'b0, rd:16'h5A5A};

    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; addr[i] = '0; wdata[i] = '0; ref_rd[i] = '0;
      for (int j = 0; j < 256; j++) begin
        known[i][j]   = 1'b0;
        ref_mem[i][j] = '0;
      end
    end

    nreset = 1'b0;
    repeat (3) step();
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    nreset = 1'b1;
    step();

    // Directed table on instance 0 (DEPTH=200, WAIT_STATES=2).
    for (int i = 0; i < 9; i++) begin
      model(0, tbl[i].r, tbl[i].w, int'(tbl[i].a), tbl[i].wd, mlat, me, mrd);
      run_txn(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].hold, lat, e, rd);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(mlat));
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
    end

    // Reset in WAIT of a write: CAFE must never reach address 0x20.
    mw[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 16'hCAFE;
    step();
    step();
    chk("wait_busy", 32'(busy[0]), 32'd1);
    #2 nreset = 1'b0;
    #1;
    chk_reset_outputs(0);
    mw[0] = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    step();
    model(0, 1'b1, 1'b0, 32'h20, 16'h0, mlat, me, mrd);
    run_txn(0, 1'b1, 1'b0, 8'h20, 16'h0, 0, lat, e, rd);
    chk("after_wait_reset_rdata", 32'(rd), 32'h1111);
    chk("after_wait_reset_err", 32'(e), 32'd0);

    // Asynchronous reset while ACK is held in RESP.
    mr[0] = 1'b1; addr[0] = 8'h10;
    step();
    repeat (3) step();
    chk("resp_ack", 32'(ack[0]), 32'd1);
    chk("resp_rdata", 32'(rdata[0]), 32'hBEEF);
    #2 nreset = 1'b0;
    #1;
    chk_reset_outputs(0);
    mr[0] = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    step();

    // Zero wait states on instance 1.
    model(1, 1'b0, 1'b1, 5, 16'h7777, mlat, me, mrd);
    run_txn(1, 1'b0, 1'b1, 8'h05, 16'h7777, 0, lat, e, rd);
    chk("ws0_write_latency", 32'(lat), 32'd1);
    model(1, 1'b1, 1'b0, 5, 16'h0, mlat, me, mrd);
    run_txn(1, 1'b1, 1'b0, 8'h05, 16'h0, 0, lat, e, rd);
    chk("ws0_read_latency", 32'(lat), 32'd1);
    chk("ws0_read_rdata", 32'(rd), 32'h7777);
    model(1, 1'b1, 1'b1, 5, 16'h0, mlat, me, mrd);
    run_txn(1, 1'b1, 1'b1, 8'h05, 16'h0, 0, lat, e, rd);
    chk("ws0_illegal_latency", 32'(lat), 32'd1);
    chk("ws0_illegal_err", 32'(e), 32'd1);

    // Random transactions against the model.
    for (int n = 0; n < 200; n++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        r = 1'b1; w = 1'b1;
      end else begin
        r = 1'($urandom_range(0, 1));
        w = !r;
      end
      a = ($urandom_range(0, 1) == 1) ? int'(pool[$urandom_range(0, 7)])
                                      : int'($urandom_range(0, 255));
      if (r && !w && a < depth_of(d) && !known[d][a]) begin
        r = 1'b0; w = 1'b1;
      end
      rd = 16'($urandom);
      model(d, r, w, a, rd, mlat, me, mrd);
      run_txn(d, r, w, 8'(a), rd, int'($urandom_range(0, 3)), lat, e, rd);
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_err", n), 32'(e), 32'(me));
      chk($sformatf("rnd%0d_rdata", n), 32'(rd), 32'(mrd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
